// File: rtl/mem_wb_reg_pkg.sv
// rtl/mem_wb_reg_pkg.sv - shared pipeline constants for the M/W stage register
package mem_wb_reg_pkg;

   localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
   localparam int          REG_ADDR_W   = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = '0;

   // Cycles until a stage's result can be forwarded.
   typedef enum logic [1:0] {
      TNEW_0 = 2'd0,
      TNEW_1 = 2'd1,
      TNEW_2 = 2'd2
   } tnew_e;

endpackage

// File: rtl/mem_wb_reg_if.sv
// rtl/mem_wb_reg_if.sv - M-stage input bundle and W-stage output bundle
interface mem_wb_reg_if #(
   parameter int WIDTH = 32
);
   import mem_wb_reg_pkg::*;

   logic             m_valid;
   logic [31:0]      m_pc;
   logic [31:0]      m_instr;
   logic [WIDTH-1:0] m_alu;
   logic [WIDTH-1:0] m_rdata;
   reg_addr_t        m_waddr;
   logic             m_regwrite;
   logic             m_memtoreg;

   logic             w_valid;
   logic [31:0]      w_pc;
   logic [31:0]      w_instr;
   logic [WIDTH-1:0] w_alu;
   logic [WIDTH-1:0] w_rdata;
   logic             w_sel;
   reg_addr_t        w_waddr;
   logic             w_regwrite;
   logic [1:0]       w_tnew;
   logic             w_retire;

   modport master (
      output m_valid, m_pc, m_instr, m_alu, m_rdata, m_waddr, m_regwrite, m_memtoreg,
      input  w_valid, w_pc, w_instr, w_alu, w_rdata, w_sel, w_waddr, w_regwrite,
             w_tnew, w_retire
   );

   modport slave (
      input  m_valid, m_pc, m_instr, m_alu, m_rdata, m_waddr, m_regwrite, m_memtoreg,
      output w_valid, w_pc, w_instr, w_alu, w_rdata, w_sel, w_waddr, w_regwrite,
             w_tnew, w_retire
   );

endinterface

// File: rtl/mem_wb_reg_field.sv
// rtl/mem_wb_reg_field.sv - pipe_field_reg: generic field register with reset, flush and load enable
module pipe_field_reg #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_d,
   input  logic [WIDTH-1:0] i_flush_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= RST_VAL;
      end else if (i_flush) begin
         r_q <= i_flush_d;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MIPS M->W pipeline register with writeback-mux select and retire strobe
// Optional retire counter output enabled by MEM_WB_RETIRE_CNT_EN.
module mem_wb_reg
   import mem_wb_reg_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEF,
   parameter int          WIDTH    = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic flush,
   mem_wb_reg_if.slave bus
`ifdef MEM_WB_RETIRE_CNT_EN
   ,
   output logic [31:0] retire_cnt
`endif
);

   // Writes to $0 and from bubbles are dropped here so forwarding never sees them.
   logic      w_qual_we;
   reg_addr_t w_qual_waddr;
   logic      w_qual_sel;
   logic      w_retire_next;

   assign w_qual_we     = bus.m_regwrite & bus.m_valid & (bus.m_waddr != ZERO_REG);
   assign w_qual_waddr  = w_qual_we ? bus.m_waddr : ZERO_REG;
   assign w_qual_sel    = bus.m_memtoreg & bus.m_valid;
   assign w_retire_next = en & ~flush & bus.m_valid;

   pipe_field_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_valid (
      .clk(clk), .rst(reset), .i_en(en), .i_flush(flush),
      .i_d(bus.m_valid), .i_flush_d(1'b0), .o_q(bus.w_valid)
   );

   pipe_field_reg #(.WIDTH(32), .RST_VAL(PC_RESET)) u_pc (
      .clk(clk), .rst(reset), .i_en(en), .i_flush(flush),
      .i_d(bus.m_pc), .i_flush_d(bus.m_pc), .o_q(bus.w_pc)
   );

   pipe_field_reg #(.WIDTH(32), .RST_VAL(32'd0)) u_instr (
      .clk(clk), .rst(reset), .i_en(en), .i_flush(flush),
      .i_d(bus.m_instr), .i_flush_d(32'd0), .o_q(bus.w_instr)
   );

   pipe_field_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_alu (
      .clk(clk), .rst(reset), .i_en(en), .i_flush(flush),
      .i_d(bus.m_alu), .i_flush_d({WIDTH{1'b0}}), .o_q(bus.w_alu)
   );

   pipe_field_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_rdata (
      .clk(clk), .rst(reset), .i_en(en), .i_flush(flush),
      .i_d(bus.m_rdata), .i_flush_d({WIDTH{1'b0}}), .o_q(bus.w_rdata)
   );

   pipe_field_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_sel (
      .clk(clk), .rst(reset), .i_en(en), .i_flush(flush),
      .i_d(w_qual_sel), .i_flush_d(1'b0), .o_q(bus.w_sel)
   );

   pipe_field_reg #(.WIDTH(REG_ADDR_W), .RST_VAL(ZERO_REG)) u_waddr (
      .clk(clk), .rst(reset), .i_en(en), .i_flush(flush),
      .i_d(w_qual_waddr), .i_flush_d(ZERO_REG), .o_q(bus.w_waddr)
   );

   pipe_field_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_regwrite (
      .clk(clk), .rst(reset), .i_en(en), .i_flush(flush),
      .i_d(w_qual_we), .i_flush_d(1'b0), .o_q(bus.w_regwrite)
   );

   // Retire reloads every edge so a stall drops it to 0 instead of repeating it.
   pipe_field_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_retire (
      .clk(clk), .rst(reset), .i_en(1'b1), .i_flush(1'b0),
      .i_d(w_retire_next), .i_flush_d(1'b0), .o_q(bus.w_retire)
   );

   assign bus.w_tnew = TNEW_0;

`ifdef MEM_WB_RETIRE_CNT_EN
   logic [31:0] r_retire_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_retire_cnt <= 32'd0;
      end else if (w_retire_next) begin
         r_retire_cnt <= r_retire_cnt + 32'd1;
      end
   end

   assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// tb/tb_mem_wb_reg.sv - scoreboard bench for mem_wb_reg
module tb_mem_wb_reg;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic        dchk;
      logic        sel;
      logic [4:0]  waddr;
      logic        rw;
      logic        retire;
      logic [31:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en = 1'b0;
   logic flush = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] exp_cnt = 32'd0;
   exp_t sb_q[$];

   mem_wb_reg_if #(.WIDTH(32)) bus ();

`ifdef MEM_WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt;
`endif

   mem_wb_reg #(.PC_RESET(32'h0000_3000), .WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .flush(flush),
      .bus(bus)
`ifdef MEM_WB_RETIRE_CNT_EN
      ,
      .retire_cnt(retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".valid"},  {31'd0, bus.w_valid},    32'd0);
      chk({tag, ".pc"},     bus.w_pc,                32'h0000_3000);
      chk({tag, ".instr"},  bus.w_instr,             32'd0);
      chk({tag, ".alu"},    bus.w_alu,               32'd0);
      chk({tag, ".rdata"},  bus.w_rdata,             32'd0);
      chk({tag, ".sel"},    {31'd0, bus.w_sel},      32'd0);
      chk({tag, ".waddr"},  {27'd0, bus.w_waddr},    32'd0);
      chk({tag, ".rw"},     {31'd0, bus.w_regwrite}, 32'd0);
      chk({tag, ".tnew"},   {30'd0, bus.w_tnew},     32'd0);
      chk({tag, ".retire"}, {31'd0, bus.w_retire},   32'd0);
`ifdef MEM_WB_RETIRE_CNT_EN
      chk({tag, ".cnt"},    retire_cnt,              32'd0);
`endif
   endtask

   // Drive one M-stage vector and queue the hand-computed W-stage result for the next edge.
   task automatic step(input logic i_en, input logic i_fl, input logic v,
                       input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [4:0] wa, input logic rw, input logic mtr,
                       input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic [31:0] e_alu, input logic [31:0] e_rdata, input logic e_dchk,
                       input logic e_sel, input logic [4:0] e_wa, input logic e_rw,
                       input logic e_ret);
      exp_t e;
      @(posedge clk);
      #2;
      en             = i_en;
      flush          = i_fl;
      bus.m_valid    = v;
      bus.m_pc       = pc;
      bus.m_instr    = instr;
      bus.m_alu      = alu;
      bus.m_rdata    = rdata;
      bus.m_waddr    = wa;
      bus.m_regwrite = rw;
      bus.m_memtoreg = mtr;
      if (e_ret) exp_cnt = exp_cnt + 32'd1;
      e.valid  = e_valid;
      e.pc     = e_pc;
      e.instr  = e_instr;
      e.alu    = e_alu;
      e.rdata  = e_rdata;
      e.dchk   = e_dchk;
      e.sel    = e_sel;
      e.waddr  = e_wa;
      e.rw     = e_rw;
      e.retire = e_ret;
      e.cnt    = exp_cnt;
      sb_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("w_valid",    {31'd0, bus.w_valid},    {31'd0, e.valid});
            chk("w_pc",       bus.w_pc,                e.pc);
            chk("w_instr",    bus.w_instr,             e.instr);
            if (e.dchk) begin
               chk("w_alu",   bus.w_alu,               e.alu);
               chk("w_rdata", bus.w_rdata,             e.rdata);
            end
            chk("w_sel",      {31'd0, bus.w_sel},      {31'd0, e.sel});
            chk("w_waddr",    {27'd0, bus.w_waddr},    {27'd0, e.waddr});
            chk("w_regwrite", {31'd0, bus.w_regwrite}, {31'd0, e.rw});
            chk("w_tnew",     {30'd0, bus.w_tnew},     32'd0);
            chk("w_retire",   {31'd0, bus.w_retire},   {31'd0, e.retire});
`ifdef MEM_WB_RETIRE_CNT_EN
            chk("retire_cnt", retire_cnt,              e.cnt);
`endif
         end
      end
   end

   initial begin : stimulus
      bus.m_valid = 1'b0; bus.m_pc = 32'd0; bus.m_instr = 32'd0; bus.m_alu = 32'd0;
      bus.m_rdata = 32'd0; bus.m_waddr = 5'd0; bus.m_regwrite = 1'b0; bus.m_memtoreg = 1'b0;
      #23;
      check_reset("rst_init");
      @(negedge clk);
      reset = 1'b0;

      // en fl v  pc            instr         alu           rdata         wa  rw mtr | expected W
      step(1, 0, 1, 32'h3004, 32'h0232_8020, 32'h1234_5678, 32'h0,        5'd8,  1, 0,
           1, 32'h3004, 32'h0232_8020, 32'h1234_5678, 32'h0, 1, 0, 5'd8, 1, 1);
      step(1, 0, 1, 32'h3008, 32'h8C09_0004, 32'h0000_1004, 32'hDEAD_BEEF, 5'd9, 1, 1,
           1, 32'h3008, 32'h8C09_0004, 32'h0000_1004, 32'hDEAD_BEEF, 1, 1, 5'd9, 1, 1);
      step(1, 0, 1, 32'h300C, 32'h0000_0020, 32'h0000_0005, 32'h0,        5'd0,  1, 0,
           1, 32'h300C, 32'h0000_0020, 32'h0000_0005, 32'h0, 1, 0, 5'd0, 0, 1);
      step(1, 0, 0, 32'h3010, 32'h8C07_0000, 32'h0000_0009, 32'h0000_00AA, 5'd7, 1, 1,
           0, 32'h3010, 32'h8C07_0000, 32'h0000_0009, 32'h0000_00AA, 1, 0, 5'd0, 0, 0);
      step(1, 0, 1, 32'h3014, 32'h0000_0001, 32'h0000_0077, 32'h0000_0055, 5'd31, 1, 0,
           1, 32'h3014, 32'h0000_0001, 32'h0000_0077, 32'h0000_0055, 1, 0, 5'd31, 1, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 32'h4000 + i, 32'hFFFF_0000, 32'h0000_FFFF, 32'h1, 5'd3, 1, 1,
              1, 32'h3014, 32'h0000_0001, 32'h0000_0077, 32'h0000_0055, 1, 0, 5'd31, 1, 0);
      end
      step(0, 1, 1, 32'h3018, 32'h0000_ABCD, 32'h0000_0011, 32'h0000_0022, 5'd4, 1, 1,
           0, 32'h3018, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 0);
      step(1, 1, 1, 32'h301C, 32'h0000_ABCE, 32'h0000_0012, 32'h0000_0023, 5'd5, 1, 0,
           0, 32'h301C, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 0);
      step(1, 0, 1, 32'h3020, 32'h0000_1111, 32'hCAFE_0001, 32'hBEEF_0002, 5'd2, 1, 1,
           1, 32'h3020, 32'h0000_1111, 32'hCAFE_0001, 32'hBEEF_0002, 1, 1, 5'd2, 1, 1);
      step(0, 0, 1, 32'h3024, 32'h0000_2222, 32'h0, 32'h0, 5'd6, 1, 0,
           1, 32'h3020, 32'h0000_1111, 32'hCAFE_0001, 32'hBEEF_0002, 1, 1, 5'd2, 1, 0);

      // Reset asserted mid-cycle while stalled must clear immediately.
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_reset("rst_stall");
      @(negedge clk);
      reset = 1'b0;
      exp_cnt = 32'd0;

      step(1, 0, 1, 32'h3028, 32'h0000_3333, 32'h0000_0042, 32'h0, 5'd10, 1, 0,
           1, 32'h3028, 32'h0000_3333, 32'h0000_0042, 32'h0, 1, 0, 5'd10, 1, 1);
      step(1, 0, 0, 32'h302C, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0,
           0, 32'h302C, 32'h0, 32'h0, 32'h0, 1, 0, 5'd0, 0, 0);

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
      #2;
      chk("scoreboard_drain", sb_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
